rr_mux_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4-to-1 data mux between four requesters.
- Drives the mux select and a one-hot grant so exactly one requester owns the mux path at a time.
- Sits between the requester blocks and the mux; sel wires directly to the mux select.
- The hold-limit counter is a 4-bit up-counter of the same style as the team's existing counter.

---
 rtl/rr_mux_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 data mux.
// Optional owner hold limit: define ARB_HOLD_LIMIT_EN (cap set by HOLD_MAX).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; gnt=0, sel keeps its last value
// GRANT | one requester owns the mux; gnt=onehot(sel), busy=1
module rr_mux_arbiter #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;

    logic [3:0] others;
    logic       owner_req;
    logic       release_now;
    logic       preempt;
    logic       handoff;
    logic [1:0] owner_next;
    logic [1:0] scan_start;
    logic [3:0] cand;
    logic [1:0] win;
    logic       load_new;

    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
        $error("rr_mux_arbiter: HOLD_MAX must be in 1..15");
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] hold_q, hold_d;
`endif

    // First set bit of cand scanning start, start+1, start+2, start+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] cand_v, input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (cand_v[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;

        // gnt_q is the owner one-hot in GRANT and zero in IDLE.
        others      = req & ~gnt_q;
        owner_req   = |(req & gnt_q);
        release_now = (state_q == GRANT) && !owner_req;
`ifdef ARB_HOLD_LIMIT_EN
        preempt     = (state_q == GRANT) && owner_req && (hold_q >= HOLD_LAST) && (|others);
`else
        preempt     = 1'b0;
`endif
        handoff     = release_now || preempt;
        owner_next  = sel_q + 2'd1;
        scan_start  = handoff ? owner_next : ptr_q;
        cand        = (state_q == IDLE) ? req : others;
        win         = rr_pick(cand, scan_start);
        load_new    = ((state_q == IDLE) && (|req)) || (handoff && (|others));

        if (handoff) begin
            ptr_d = owner_next;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (handoff && !(|others)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_new) begin
            gnt_d = onehot(win);
            sel_d = win;
        end else if (handoff) begin
            gnt_d = 4'b0000;
        end

`ifdef ARB_HOLD_LIMIT_EN
        hold_d = hold_q;
        if (load_new) begin
            hold_d = 4'd0;
        end else if ((state_q == GRANT) && (hold_q != 4'd15)) begin
            hold_d = hold_q + 4'd1;
        end
`endif
    end

    always_comb begin
        gnt  = gnt_q;
        sel  = sel_q;
        busy = |gnt_q;
    end

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_matches_sel: assert property (@(posedge clk) disable iff (rst) busy |-> (gnt == onehot(sel)));
    a_busy_state: assert property (@(posedge clk) disable iff (rst) busy == (state_q == GRANT));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; expected {gnt,sel,busy} go through a scoreboard queue.
// Hold-limit steps run only when ARB_HOLD_LIMIT_EN is defined (HOLD_MAX=4).
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt),
        .sel (sel),
        .busy(busy)
    );

    // Drive one cycle of inputs, queue the expected registered result, check after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                        input logic [1:0] es, input string tag);
        obs_t e;
        obs_t got;
        rst = r;
        req = rq;
        e.gnt  = eg;
        e.sel  = es;
        e.busy = |eg;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got.gnt  = gnt;
        got.sel  = sel;
        got.busy = busy;
        e = sb.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_err++;
            $error("FAIL %s: observed gnt=%b sel=%b busy=%b expected gnt=%b sel=%b busy=%b",
                   tag, got.gnt, got.sel, got.busy, e.gnt, e.sel, e.busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);

        step(1, 4'b0000, 4'b0000, 2'd0, "reset");
        step(1, 4'b1111, 4'b0000, 2'd0, "reset_ignores_req");
        for (int i = 0; i < 5; i++) step(0, 4'b0000, 4'b0000, 2'd0, "idle_after_reset");

        // Two requesters, each owner releases after 3 grant cycles.
        step(0, 4'b1010, 4'b0010, 2'd1, "rr_first_owner1");
        step(0, 4'b1010, 4'b0010, 2'd1, "rr_owner1_hold");
        step(0, 4'b1010, 4'b0010, 2'd1, "rr_owner1_hold");
        step(0, 4'b1000, 4'b1000, 2'd3, "rr_handoff_to_3");
        step(0, 4'b1000, 4'b1000, 2'd3, "rr_owner3_hold");
        step(0, 4'b1000, 4'b1000, 2'd3, "rr_owner3_hold");
        step(0, 4'b0010, 4'b0010, 2'd1, "rr_wrap_to_1");
        step(0, 4'b0000, 4'b0000, 2'd1, "release_to_idle_sel_kept");

        // One-cycle pulse from requester 2.
        step(0, 4'b0100, 4'b0100, 2'd2, "pulse_grant");
        step(0, 4'b0000, 4'b0000, 2'd2, "pulse_release");

        // All requesting; order follows the pointer (3 after owner 2 ended).
        step(0, 4'b1111, 4'b1000, 2'd3, "all_req_ptr3");
        step(0, 4'b0111, 4'b0001, 2'd0, "handoff_wrap_0");
        step(0, 4'b0110, 4'b0010, 2'd1, "handoff_1");
        step(0, 4'b0100, 4'b0100, 2'd2, "handoff_2");

        // Reset mid-grant, then pointer must be back at 0.
        step(1, 4'b0100, 4'b0000, 2'd0, "reset_mid_grant");
        step(0, 4'b1111, 4'b0001, 2'd0, "post_reset_ptr0");
        step(0, 4'b1110, 4'b0010, 2'd1, "release_owner0");
        step(0, 4'b1111, 4'b0010, 2'd1, "reraise_not_continuation");
        step(0, 4'b1101, 4'b0100, 2'd2, "handoff_skip_to_2");
        step(0, 4'b0000, 4'b0000, 2'd2, "idle_again");
        step(0, 4'b0010, 4'b0010, 2'd1, "idle_scan_from_ptr3");
        step(0, 4'b0000, 4'b0000, 2'd1, "idle_sel_kept");

`ifndef ARB_HOLD_LIMIT_EN
        // Without the hold limit the owner keeps the mux while others wait.
        step(0, 4'b0011, 4'b0001, 2'd0, "grant_0_from_ptr2");
        for (int i = 0; i < 10; i++) step(0, 4'b0011, 4'b0001, 2'd0, "no_preempt");
        step(0, 4'b0010, 4'b0010, 2'd1, "release_then_1");
        step(0, 4'b0000, 4'b0000, 2'd1, "final_idle");
`else
        step(1, 4'b0000, 4'b0000, 2'd0, "hold_reset");
        step(0, 4'b0001, 4'b0001, 2'd0, "hold_grant0");
        for (int i = 0; i < 3; i++) step(0, 4'b0101, 4'b0001, 2'd0, "hold_owner0_waiting2");
        step(0, 4'b0101, 4'b0100, 2'd2, "preempt_to_2");
        step(0, 4'b0001, 4'b0001, 2'd0, "return_to_0");
        for (int i = 0; i < 20; i++) step(0, 4'b0001, 4'b0001, 2'd0, "alone_no_preempt");
        step(0, 4'b1001, 4'b1000, 2'd3, "saturated_preempt_to_3");
        step(0, 4'b0000, 4'b0000, 2'd3, "hold_final_idle");
`endif

        if (sb.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
